// File: rtl/ddr5_wr_pkg.sv
// Shared types and constants for the DDR5 write amble controller.
// State/kind enums, preamble length table, DQS pair patterns.
package ddr5_wr_pkg;

  typedef enum logic [2:0] {
    A_IDLE,
    A_PRE,
    A_DATA,
    A_POST,
    A_INTER
  } amble_state_e;

  typedef enum logic [1:0] {
    PRE_2TCK = 2'b00,
    PRE_3TCK = 2'b01,
    PRE_4TCK = 2'b10,
    PRE_RSVD = 2'b11
  } pre_mode_e;

  typedef enum logic [1:0] {
    K_PRE,
    K_POST,
    K_INTER
  } amble_kind_e;

  // Indexed by pre_mode_i; the reserved code falls back to 2tCK.
  localparam logic [3:0][2:0] PRE_LEN = {
    3'd2, 3'd4, 3'd3, 3'd2
  };

  localparam logic [1:0] DQS_LO = 2'b00;
  localparam logic [1:0] DQS_HI = 2'b10;

  localparam int BEATS_BL16 = 8;
  localparam int BEATS_BL8  = 4;

  typedef struct packed {
    logic [1:0] pre_bits;
    logic       pre_valid;
    logic       pre_done;
    logic       post_done;
    logic [1:0] inter_bits;
    logic       inter_done;
    logic       burst_done;
    logic       wr_done;
    logic       crc_done;
  } amble_out_t;

endpackage

// File: rtl/ddr5_wr_amble_ctrl_shift.sv
// Loadable down-counter plus DQS pattern mux for one amble slot.
// bits_o/last_o describe the slot emitted on this clock.
module ddr5_amble_shift
  import ddr5_wr_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          enable_i,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [CW-1:0] len_i,
  input  logic [1:0]    kind_i,
  output logic [1:0]    bits_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] rem;

  // Slots left including the one emitted now.
  assign rem    = load_i ? len_i : cnt_q;
  assign last_o = (rem <= CW'(1));

  // Pattern for the current slot, keyed on slots remaining.
  always_comb begin
    bits_o = DQS_LO;
    unique case (amble_kind_e'(kind_i))
      K_PRE:   bits_o = last_o ? DQS_HI : DQS_LO;
      K_POST:  bits_o = (rem == CW'(2)) ? DQS_HI : DQS_LO;
      K_INTER: bits_o = rem[0] ? DQS_HI : DQS_LO;
      default: bits_o = DQS_LO;
    endcase
  end

  // Count down one slot per emitted pattern.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (enable_i && (load_i || step_i)) begin
      cnt_q <= last_o ? '0 : rem - CW'(1);
    end
  end

endmodule

// File: rtl/ddr5_wr_amble_ctrl.sv
// DQS pre/post/interamble generator and data beat counter.
// Optional sticky protocol checker: define WR_AMBLE_ERR_EN.
module ddr5_wr_amble_ctrl
  import ddr5_wr_pkg::*;
#(
  parameter int pDRAM_SIZE = 4,
  parameter int pGAP_W     = 4,
  parameter int pINTER_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              wr_en_i,
  input  logic              preamble_state_i,
  input  logic              data_state_i,
  input  logic              interamble_valid_i,
  input  logic [1:0]        pre_mode_i,
  input  logic              post_mode_i,
  input  logic [1:0]        burstlength_i,
  input  logic              crc_generate_i,
  output logic [1:0]        preamble_bits_o,
  output logic              preamble_valid_o,
  output logic              preamble_done_o,
  output logic              postamble_done_o,
  output logic              interamble_o,
  output logic [1:0]        interamble_bits_o,
  output logic              interamble_done_o,
  output logic [pGAP_W-1:0] gap_o,
  output logic              data_burst_done_o,
  output logic              wrdata_done_o,
`ifdef WR_AMBLE_ERR_EN
  output logic              err_o,
`endif
  output logic              wrdata_crc_done_o
);

  localparam int CW = (pGAP_W > 3) ? pGAP_W : 3;

  wire unused_dram = (pDRAM_SIZE > 0);

  amble_state_e      state_q, state_d;
  amble_out_t        out_q, out_d;
  logic [2:0]        beat_q, beat_d;
  logic [pGAP_W-1:0] gap_q, gap_cap_q;
  logic              inter_q;
  logic              frz;
  logic              bl8;
  logic              sh_load, sh_step;
  logic [CW-1:0]     sh_len;
  amble_kind_e       sh_kind;
  logic [1:0]        sh_bits;
  logic              sh_last;

  assign bl8 = (burstlength_i == 2'b01);

  // Merge decision is frozen from A_DATA exit to amble exit.
  assign frz = (state_q == A_POST) ||
               (state_q == A_INTER) ||
               ((state_q == A_DATA) && interamble_valid_i);

  ddr5_amble_shift #(
    .CW(CW)
  ) u_shift (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .load_i   (sh_load),
    .step_i   (sh_step),
    .len_i    (sh_len),
    .kind_i   (sh_kind),
    .bits_o   (sh_bits),
    .last_o   (sh_last)
  );

  // Next state, shifter control and next registered outputs.
  always_comb begin
    state_d = state_q;
    out_d   = '0;
    beat_d  = beat_q;
    sh_load = 1'b0;
    sh_step = 1'b0;
    sh_len  = '0;
    sh_kind = K_PRE;
    unique case (state_q)
      A_IDLE: begin
        if (preamble_state_i) begin
          sh_load = 1'b1;
          sh_len  = CW'(PRE_LEN[pre_mode_i]);
          state_d = A_PRE;
        end
      end
      A_PRE: begin
        sh_step = 1'b1;
      end
      A_DATA: begin
        if (interamble_valid_i) begin
          sh_load = 1'b1;
          beat_d  = '0;
          if (inter_q) begin
            sh_kind = K_INTER;
            sh_len  = (gap_cap_q == '0) ?
                      CW'(1) : CW'(gap_cap_q);
            state_d = A_INTER;
          end else begin
            sh_kind = K_POST;
            sh_len  = post_mode_i ? CW'(2) : CW'(1);
            state_d = A_POST;
          end
        end else if (data_state_i) begin
          out_d.burst_done = bl8 &&
            (beat_q == 3'(BEATS_BL8 - 1));
          out_d.wr_done = crc_generate_i &&
            (beat_q == 3'(BEATS_BL16 - 1));
          out_d.crc_done = !crc_generate_i &&
            (beat_q == 3'(BEATS_BL16 - 1));
          beat_d = beat_q + 3'd1;
        end
      end
      A_POST: begin
        sh_step = 1'b1;
        sh_kind = K_POST;
      end
      A_INTER: begin
        sh_step = 1'b1;
        sh_kind = K_INTER;
      end
      default: state_d = A_IDLE;
    endcase
    // Postamble shares the interamble DQS pair.
    if (sh_load || sh_step) begin
      unique case (sh_kind)
        K_PRE: begin
          out_d.pre_bits  = sh_bits;
          out_d.pre_valid = 1'b1;
          out_d.pre_done  = sh_last;
          if (sh_last) state_d = A_DATA;
        end
        K_POST: begin
          out_d.inter_bits = sh_bits;
          out_d.post_done  = sh_last;
          if (sh_last) state_d = A_IDLE;
        end
        K_INTER: begin
          out_d.inter_bits = sh_bits;
          out_d.inter_done = sh_last;
          if (sh_last) state_d = A_DATA;
        end
        default: ;
      endcase
    end
  end

  // State, output, beat and gap registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= A_IDLE;
      out_q     <= '0;
      beat_q    <= '0;
      gap_q     <= '0;
      gap_cap_q <= '0;
      inter_q   <= 1'b0;
    end else if (enable_i) begin
      state_q <= state_d;
      out_q   <= out_d;
      beat_q  <= beat_d;
      if (wr_en_i) begin
        gap_q <= '0;
      end else if (gap_q != '1) begin
        gap_q <= gap_q + pGAP_W'(1);
      end
      if (!frz) begin
        inter_q   <= wr_en_i &&
                     (int'(gap_q) <= pINTER_MAX);
        gap_cap_q <= gap_q;
      end
    end
  end

`ifdef WR_AMBLE_ERR_EN
  logic err_q;

  // Sticky flag for out-of-order FSM state inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (enable_i) begin
      if ((data_state_i &&
           ((state_q == A_IDLE) ||
            (state_q == A_PRE))) ||
          (preamble_state_i &&
           (state_q == A_DATA)) ||
          (pre_mode_e'(pre_mode_i) == PRE_RSVD)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`endif

  assign preamble_bits_o   = out_q.pre_bits;
  assign preamble_valid_o  = out_q.pre_valid;
  assign preamble_done_o   = out_q.pre_done;
  assign postamble_done_o  = out_q.post_done;
  assign interamble_o      = inter_q;
  assign interamble_bits_o = out_q.inter_bits;
  assign interamble_done_o = out_q.inter_done;
  assign gap_o             = gap_q;
  assign data_burst_done_o = out_q.burst_done;
  assign wrdata_done_o     = out_q.wr_done;
  assign wrdata_crc_done_o = out_q.crc_done;

endmodule

// File: tb/tb_ddr5_wr_amble_ctrl.sv
// Directed bench for ddr5_wr_amble_ctrl.
// Hand-computed expectations, one checker task.
module tb_ddr5_wr_amble_ctrl;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       wr_en;
  logic       pre_state;
  logic       data_state;
  logic       iv;
  logic [1:0] pre_mode;
  logic       post_mode;
  logic [1:0] bl;
  logic       crc;
  logic [1:0] pre_bits;
  logic       pre_valid;
  logic       pre_done;
  logic       post_done;
  logic       inter;
  logic [1:0] inter_bits;
  logic       inter_done;
  logic [3:0] gap;
  logic       burst;
  logic       wrd;
  logic       crcd;
`ifdef WR_AMBLE_ERR_EN
  logic       err;
`endif

  int errs;
  int checks;

  logic [15:0] outs;
  assign outs = {pre_bits, pre_valid, pre_done,
                 post_done, inter, inter_bits,
                 inter_done, gap, burst, wrd, crcd};

  ddr5_wr_amble_ctrl #(
    .pDRAM_SIZE(4),
    .pGAP_W(4),
    .pINTER_MAX(4)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .enable_i           (enable),
    .wr_en_i            (wr_en),
    .preamble_state_i   (pre_state),
    .data_state_i       (data_state),
    .interamble_valid_i (iv),
    .pre_mode_i         (pre_mode),
    .post_mode_i        (post_mode),
    .burstlength_i      (bl),
    .crc_generate_i     (crc),
    .preamble_bits_o    (pre_bits),
    .preamble_valid_o   (pre_valid),
    .preamble_done_o    (pre_done),
    .postamble_done_o   (post_done),
    .interamble_o       (inter),
    .interamble_bits_o  (inter_bits),
    .interamble_done_o  (inter_done),
    .gap_o              (gap),
    .data_burst_done_o  (burst),
    .wrdata_done_o      (wrd),
`ifdef WR_AMBLE_ERR_EN
    .err_o              (err),
`endif
    .wrdata_crc_done_o  (crcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    errs       = 0;
    checks     = 0;
    rst        = 1'b1;
    enable     = 1'b1;
    wr_en      = 1'b1;
    pre_state  = 1'b0;
    data_state = 1'b0;
    iv         = 1'b0;
    pre_mode   = 2'b01;
    post_mode  = 1'b0;
    bl         = 2'b00;
    crc        = 1'b0;
    tick;
    tick;
    chk("reset", 32'(outs), 32'd0);

    rst       = 1'b0;
    pre_state = 1'b1;
    tick;
    chk("pre3_s0", {pre_bits, pre_valid, pre_done}, 4'b0010);
    tick;
    chk("pre3_s1", {pre_bits, pre_valid, pre_done}, 4'b0010);
    tick;
    chk("pre3_s2", {pre_bits, pre_valid, pre_done}, 4'b1011);
    pre_state = 1'b0;

    bl         = 2'b01;
    crc        = 1'b1;
    data_state = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk($sformatf("bl8_b%0d", i), {burst, wrd, crcd},
          {(i == 3), (i == 7), 1'b0});
    end
    chk("pre_off", {pre_valid, pre_done}, 2'b00);

    bl  = 2'b00;
    crc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk($sformatf("bl16_b%0d", i), {burst, wrd, crcd},
          {1'b0, 1'b0, (i == 7)});
    end
    data_state = 1'b0;

    wr_en = 1'b0;
    tick;
    tick;
    chk("gap2", gap, 4'd2);
    wr_en = 1'b1;
    tick;
    chk("inter_flag", {inter, gap}, {1'b1, 4'd0});
    iv = 1'b1;
    tick;
    chk("inter_s0", {inter_bits, inter_done, inter}, 4'b0001);
    iv = 1'b0;
    tick;
    chk("inter_s1", {inter_bits, inter_done, inter}, 4'b1011);

    post_mode = 1'b1;
    wr_en     = 1'b0;
    repeat (20) tick;
    chk("gap_sat", {inter, gap}, {1'b0, 4'hF});
    iv = 1'b1;
    tick;
    chk("post_s0", {inter_bits, post_done}, 3'b100);
    iv    = 1'b0;
    wr_en = 1'b1;
    tick;
    chk("post_s1", {inter_bits, post_done, gap},
        {2'b00, 1'b1, 4'd0});

    pre_mode  = 2'b00;
    pre_state = 1'b1;
    tick;
    chk("pre2_s0", {pre_bits, pre_valid, pre_done, post_done},
        5'b00100);
    tick;
    chk("pre2_s1", {pre_bits, pre_valid, pre_done, post_done},
        5'b10110);
    pre_state = 1'b0;

    bl         = 2'b01;
    crc        = 1'b1;
    data_state = 1'b1;
    wr_en      = 1'b0;
    for (int i = 0; i < 6; i++) tick;
    chk("gap6", gap, 4'd6);
    rst = 1'b1;
    tick;
    chk("rst_mid", 32'(outs), 32'd0);

    rst        = 1'b0;
    data_state = 1'b0;
    wr_en      = 1'b1;
    pre_mode   = 2'b10;
    pre_state  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("pre4_s%0d", i),
          {pre_bits, pre_valid, pre_done},
          (i == 3) ? 4'b1011 : 4'b0010);
    end
    pre_state  = 1'b0;
    data_state = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("restart_b%0d", i), burst, (i == 3));
    end

    enable = 1'b0;
    tick;
    tick;
    chk("hold", burst, 1'b1);
    enable = 1'b1;
    tick;
    chk("resume", burst, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
